dac_spi_arbiter: RTL

Shares the single AD9122 SPI transaction engine (`spi_wr_rd_single`) between two requesters. Port A is the power-up configuration sequencer. Port B is the run-time register access path (NCO retune, FIFO status polling). The arbiter grants one requester at a time and presents that requester's write, read or delay command to the engine. It holds the engine handshake until the engine completes, then returns read data and a completion pulse to the granted requester.

---
 rtl/dac_spi_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/dac_spi_arbiter.sv
// dac_spi_arbiter: shares one AD9122 SPI transaction engine between the power-up sequencer (A) and run-time access (B).
// Optional handshake watchdog is compiled in with `define DAC_SPI_ARB_TIMEOUT_EN.
module dac_spi_arbiter #(
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        i_a_valid,
    input  logic        i_b_valid,
    output logic        o_a_ready,
    output logic        o_b_ready,
    input  logic [1:0]  i_a_mode,
    input  logic [1:0]  i_b_mode,
    input  logic [6:0]  i_a_addr,
    input  logic [6:0]  i_b_addr,
    input  logic [7:0]  i_a_wdata,
    input  logic [7:0]  i_b_wdata,
    input  logic [15:0] i_a_delay,
    input  logic [15:0] i_b_delay,
    input  logic        i_a_lock,
    output logic        o_a_done,
    output logic        o_b_done,
    output logic [7:0]  o_a_rdata,
    output logic [7:0]  o_b_rdata,
    output logic        o_a_err,
    output logic        o_b_err,
    output logic [1:0]  o_eng_mode,
    output logic [15:0] o_eng_infodata,
    output logic [7:0]  o_eng_rd_info,
    output logic [15:0] o_eng_delay,
    output logic        o_eng_valid,
    input  logic        i_eng_ready,
    input  logic [7:0]  i_eng_rdata,
    output logic        o_busy,
    output logic        o_grant_b
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_RESP = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_RD  = 2'b01;
    localparam logic [1:0] MODE_RSV = 2'b11;
    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    state_t      r_state;
    logic        r_last_b;
    logic        r_grant_b;
    logic        r_a_ready;
    logic        r_b_ready;
    logic        r_a_done;
    logic        r_b_done;
    logic        r_a_err;
    logic        r_b_err;
    logic [7:0]  r_a_rdata;
    logic [7:0]  r_b_rdata;
    logic [1:0]  r_eng_mode;
    logic [15:0] r_eng_infodata;
    logic [7:0]  r_eng_rd_info;
    logic [15:0] r_eng_delay;
    logic        r_eng_valid;
    logic [3:0]  r_gap_cnt;
`ifdef DAC_SPI_ARB_TIMEOUT_EN
    logic [31:0] r_tmo_cnt;
`else
    logic        w_unused_tmo;
    assign w_unused_tmo = |32'(TIMEOUT_CYCLES);
`endif

    logic        w_cand_a;
    logic        w_cand_b;
    logic        w_pick_b;
    logic [1:0]  w_sel_mode;
    logic [6:0]  w_sel_addr;
    logic [7:0]  w_sel_wdata;
    logic [15:0] w_sel_delay;

    // Lock only masks B; on a tie the port that did not win last time goes first.
    assign w_cand_a    = i_a_valid;
    assign w_cand_b    = i_b_valid & ~i_a_lock;
    assign w_pick_b    = w_cand_b & (~w_cand_a | ~r_last_b);
    assign w_sel_mode  = w_pick_b ? i_b_mode  : i_a_mode;
    assign w_sel_addr  = w_pick_b ? i_b_addr  : i_a_addr;
    assign w_sel_wdata = w_pick_b ? i_b_wdata : i_a_wdata;
    assign w_sel_delay = w_pick_b ? i_b_delay : i_a_delay;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_last_b       <= 1'b1;
            r_grant_b      <= 1'b0;
            r_a_ready      <= 1'b0;
            r_b_ready      <= 1'b0;
            r_a_done       <= 1'b0;
            r_b_done       <= 1'b0;
            r_a_err        <= 1'b0;
            r_b_err        <= 1'b0;
            r_a_rdata      <= 8'd0;
            r_b_rdata      <= 8'd0;
            r_eng_mode     <= 2'd0;
            r_eng_infodata <= 16'd0;
            r_eng_rd_info  <= 8'd0;
            r_eng_delay    <= 16'd0;
            r_eng_valid    <= 1'b0;
            r_gap_cnt      <= 4'd0;
`ifdef DAC_SPI_ARB_TIMEOUT_EN
            r_tmo_cnt      <= 32'd0;
`endif
        end else begin
            r_a_ready <= 1'b0;
            r_b_ready <= 1'b0;
            r_a_done  <= 1'b0;
            r_b_done  <= 1'b0;
            r_a_err   <= 1'b0;
            r_b_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_cand_a || w_cand_b) begin
                        r_a_ready      <= ~w_pick_b;
                        r_b_ready      <= w_pick_b;
                        r_last_b       <= w_pick_b;
                        r_grant_b      <= w_pick_b;
                        r_eng_mode     <= w_sel_mode;
                        r_eng_infodata <= {1'b0, w_sel_addr, w_sel_wdata};
                        r_eng_rd_info  <= {1'b1, w_sel_addr};
                        r_eng_delay    <= w_sel_delay;
                        r_state        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (r_eng_mode == MODE_RSV) begin
                        r_a_done <= ~r_grant_b;
                        r_b_done <= r_grant_b;
                        r_a_err  <= ~r_grant_b;
                        r_b_err  <= r_grant_b;
                        r_state  <= S_RESP;
                    end else begin
                        r_eng_valid <= 1'b1;
`ifdef DAC_SPI_ARB_TIMEOUT_EN
                        r_tmo_cnt   <= 32'd0;
`endif
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_eng_ready) begin
                        r_eng_valid <= 1'b0;
                        r_a_done    <= ~r_grant_b;
                        r_b_done    <= r_grant_b;
                        if (r_eng_mode == MODE_RD) begin
                            if (r_grant_b) r_b_rdata <= i_eng_rdata;
                            else           r_a_rdata <= i_eng_rdata;
                        end
                        r_state <= S_RESP;
                    end
`ifdef DAC_SPI_ARB_TIMEOUT_EN
                    else if (r_tmo_cnt + 32'd1 == 32'(TIMEOUT_CYCLES)) begin
                        r_eng_valid <= 1'b0;
                        r_a_done    <= ~r_grant_b;
                        r_b_done    <= r_grant_b;
                        r_a_err     <= ~r_grant_b;
                        r_b_err     <= r_grant_b;
                        r_state     <= S_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 32'd1;
                    end
`endif
                end
                S_RESP: begin
                    r_gap_cnt <= GAP_LOAD;
                    r_state   <= S_GAP;
                end
                S_GAP: begin
                    if (r_gap_cnt == 4'd0) begin
                        r_grant_b <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_a_ready      = r_a_ready;
    assign o_b_ready      = r_b_ready;
    assign o_a_done       = r_a_done;
    assign o_b_done       = r_b_done;
    assign o_a_err        = r_a_err;
    assign o_b_err        = r_b_err;
    assign o_a_rdata      = r_a_rdata;
    assign o_b_rdata      = r_b_rdata;
    assign o_eng_mode     = r_eng_mode;
    assign o_eng_infodata = r_eng_infodata;
    assign o_eng_rd_info  = r_eng_rd_info;
    assign o_eng_delay    = r_eng_delay;
    assign o_eng_valid    = r_eng_valid;
    assign o_busy         = (r_state != S_IDLE);
    assign o_grant_b      = r_grant_b;

endmodule
